// File: rtl/fixed_pkg.sv
// fixed_pkg: shared Q24.8 fixed-point parameters, divider state encoding and divider step logic.
// Used by fixed_64_div and the Q24.8 multiplier.
package fixed_pkg;

    localparam int FRACT_BITS = 8;
    localparam int IN_W       = 32;
    localparam int OUT_W      = 64;
    localparam int DIV_ITERS  = IN_W + FRACT_BITS;

    typedef enum logic [1:0] {IDLE, DIV, FIX} div_state_t;

    // One restoring step: shift {rem, dvd} left by one, then trial-subtract the divisor.
    // The quotient bit enters at the bottom of dvd, so dvd becomes the quotient after DIV_ITERS steps.
    // rem is always below the divisor, which is at most 2^31, so the shifted value fits in IN_W+1 bits.
    function automatic logic [IN_W+DIV_ITERS:0] div_step(
        input logic [IN_W:0]        rem,
        input logic [DIV_ITERS-1:0] dvd,
        input logic [IN_W:0]        dv
    );
        logic [IN_W+1:0] sh;
        logic [IN_W+1:0] diff;
        sh   = {rem, dvd[DIV_ITERS-1]};
        diff = sh - {1'b0, dv};
        return (sh >= {1'b0, dv}) ? {diff[IN_W:0], dvd[DIV_ITERS-2:0], 1'b1}
                                  : {sh[IN_W:0], dvd[DIV_ITERS-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/fixed_64_div.sv
// fixed_64_div: sequential signed Q24.8 / Q24.8 -> Q55.8 divider, (a << 8) / b truncated toward zero.
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   start_in         request, sampled only while idle, together with a_in / b_in
//   a_in, b_in       signed Q24.8 dividend and divisor
//   busy_out         high while a division is in progress
//   done_out         one-cycle pulse when the result is valid
//   q_out            signed Q55.8 quotient, held until the next done_out
//   overflow_out     quotient lies outside the signed 32-bit range
//   div_by_zero_out  divisor was zero
module fixed_64_div
    import fixed_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [IN_W-1:0]  a_in,
    input  logic [IN_W-1:0]  b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [OUT_W-1:0] q_out,
    output logic             overflow_out,
    output logic             div_by_zero_out
);

    div_state_t             r_state;
    div_state_t             w_next;
    logic [DIV_ITERS-1:0]   r_dvd;
    logic [IN_W:0]          r_rem;
    logic [IN_W:0]          r_div;
    logic [5:0]             r_count;
    logic                   r_sign;
    logic                   r_dbz;
    logic                   r_done;
    logic [OUT_W-1:0]       r_q;
    logic                   r_ov;
    logic                   r_dbz_out;

    // A 32-bit unsigned magnitude still represents |-2^31| exactly.
    logic [IN_W-1:0]        w_abs_a;
    logic [IN_W:0]          w_abs_b;
    logic [IN_W+DIV_ITERS:0] w_step;
    logic [OUT_W-1:0]       w_mag;
    logic [OUT_W-1:0]       w_q;
    logic                   w_ov;

    assign w_abs_a = a_in[IN_W-1] ? -a_in : a_in;
    assign w_abs_b = {1'b0, b_in[IN_W-1] ? -b_in : b_in};
    assign w_step  = div_step(r_rem, r_dvd, r_div);
    assign w_mag   = {{(OUT_W-DIV_ITERS){1'b0}}, r_dvd};
    assign w_q     = r_sign ? -w_mag : w_mag;
    assign w_ov    = ($signed(w_q) < -64'sd2147483648) || ($signed(w_q) > 64'sd2147483647);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start_in ? ((b_in == '0) ? FIX : DIV) : IDLE;
            DIV:     w_next = (r_count == '0) ? FIX : DIV;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_count   <= '0;
            r_sign    <= 1'b0;
            r_dbz     <= 1'b0;
            r_done    <= 1'b0;
            r_q       <= '0;
            r_ov      <= 1'b0;
            r_dbz_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start_in) begin
                    r_dvd   <= {w_abs_a, {FRACT_BITS{1'b0}}};
                    r_div   <= w_abs_b;
                    r_rem   <= '0;
                    r_sign  <= a_in[IN_W-1] ^ b_in[IN_W-1];
                    r_count <= 6'(DIV_ITERS - 1);
                    r_dbz   <= (b_in == '0);
                end
                DIV: begin
                    {r_rem, r_dvd} <= w_step;
                    r_count        <= r_count - 6'd1;
                end
                FIX: begin
                    r_done    <= 1'b1;
                    r_q       <= r_dbz ? '0 : w_q;
                    r_ov      <= !r_dbz && w_ov;
                    r_dbz_out <= r_dbz;
                end
                default: ;
            endcase
        end
    end

    assign busy_out        = (r_state != IDLE);
    assign done_out        = r_done;
    assign q_out           = r_q;
    assign overflow_out    = r_ov;
    assign div_by_zero_out = r_dbz_out;

endmodule

// File: tb/tb_fixed_64_div.sv
// tb_fixed_64_div: directed self-checking bench for fixed_64_div.
module tb_fixed_64_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy_out;
    logic        done_out;
    logic [63:0] q_out;
    logic        overflow_out;
    logic        div_by_zero_out;

    int tests = 0;
    int fails = 0;
    int edges;

    fixed_64_div dut (
        .clk(clk), .rst(rst), .start_in(start_in), .a_in(a_in), .b_in(b_in),
        .busy_out(busy_out), .done_out(done_out), .q_out(q_out),
        .overflow_out(overflow_out), .div_by_zero_out(div_by_zero_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive start for one cycle; returns just after the sampling edge.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        a_in = a;
        b_in = b;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
    endtask

    // Count edges after the sampling edge until done_out is seen, bounded.
    task automatic wait_done(input int already, output int n);
        n = already;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done_out) break;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] q, input logic ov, input logic dbz, input int lat);
        do_start(a, b);
        chk({tag, "_busy"}, 64'(busy_out), 64'(1'b1));
        wait_done(0, edges);
        chk({tag, "_lat"}, 64'(edges), 64'(lat));
        chk({tag, "_q"}, q_out, q);
        chk({tag, "_ov"}, 64'(overflow_out), 64'(ov));
        chk({tag, "_dbz"}, 64'(div_by_zero_out), 64'(dbz));
        chk({tag, "_busy_done"}, 64'(busy_out), 64'(1'b0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy_out), 64'd0);
        chk("rst_done", 64'(done_out), 64'd0);
        chk("rst_q", q_out, 64'd0);
        chk("rst_ov", 64'(overflow_out), 64'd0);
        chk("rst_dbz", 64'(div_by_zero_out), 64'd0);
        rst = 1'b0;

        run("basic", 32'h00000180, 32'h00000080, 64'h0000000000000300, 1'b0, 1'b0, 41);
        @(posedge clk);
        #1;
        chk("done_pulse", 64'(done_out), 64'd0);
        chk("q_hold", q_out, 64'h0000000000000300);
        run("neg7_2", 32'hFFFFF900, 32'h00000200, 64'hFFFFFFFFFFFFFC80, 1'b0, 1'b0, 41);
        run("third", 32'h00000100, 32'h00000300, 64'h0000000000000055, 1'b0, 1'b0, 41);
        run("negthird", 32'hFFFFFF00, 32'h00000300, 64'hFFFFFFFFFFFFFFAB, 1'b0, 1'b0, 41);
        run("maxdiv1", 32'h7FFFFFFF, 32'h00000001, 64'h0000007FFFFFFF00, 1'b1, 1'b0, 41);
        run("minneg1", 32'h80000000, 32'hFFFFFF00, 64'h0000000080000000, 1'b1, 1'b0, 41);
        run("dbz", 32'h00000100, 32'h00000000, 64'h0000000000000000, 1'b0, 1'b1, 1);

        // start pulse during a busy division must be ignored
        do_start(32'h00000180, 32'h00000080);
        repeat (9) @(posedge clk);
        @(negedge clk);
        a_in = 32'h00000100;
        b_in = 32'h00000000;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        wait_done(10, edges);
        chk("ign_lat", 64'(edges), 64'd41);
        chk("ign_q", q_out, 64'h0000000000000300);
        chk("ign_dbz", 64'(div_by_zero_out), 64'd0);

        // back-to-back start accepted in the done_out cycle
        do_start(32'hFFFFF900, 32'h00000200);
        chk("b2b_done_drop", 64'(done_out), 64'd0);
        chk("b2b_busy", 64'(busy_out), 64'd1);
        wait_done(0, edges);
        chk("b2b_lat", 64'(edges), 64'd41);
        chk("b2b_q", q_out, 64'hFFFFFFFFFFFFFC80);

        // reset mid-operation
        run("pre_rst", 32'h7FFFFFFF, 32'h00000001, 64'h0000007FFFFFFF00, 1'b1, 1'b0, 41);
        do_start(32'h00000180, 32'h00000080);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_busy", 64'(busy_out), 64'd0);
        chk("mrst_done", 64'(done_out), 64'd0);
        chk("mrst_q", q_out, 64'd0);
        chk("mrst_ov", 64'(overflow_out), 64'd0);
        chk("mrst_dbz", 64'(div_by_zero_out), 64'd0);
        edges = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done_out) edges++;
        end
        chk("mrst_no_done", 64'(edges), 64'd0);
        run("post_rst", 32'h00000100, 32'h00000300, 64'h0000000000000055, 1'b0, 1'b0, 41);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fixed_64_div.md
Name: fixed_64_div

Overview:
Sequential signed fixed-point divider, the inverse of the team's Q24.8 multiplier. It takes a Q24.8 dividend and a Q24.8 divisor and returns a Q55.8 quotient, computed as (a << 8) / b and truncated toward zero. Internally it is a radix-2 restoring divider, one quotient bit per clock, behind a start/done handshake. It sits alongside the multiplier in the fixed-point datapath of the gradient/value-difference pipeline.

Parameters:
FRACT_BITS, 8, fractional bits of the Q format.
IN_W, 32, operand width (Q24.8).
OUT_W, 64, quotient width (Q55.8).

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
start_in  input  1  request; sampled only in IDLE
a_in  input  32  dividend, signed Q24.8; sampled with start_in
b_in  input  32  divisor, signed Q24.8; sampled with start_in
busy_out  output  1  high while a division is in progress
done_out  output  1  one-cycle pulse when the result is valid
q_out  output  64  signed Q55.8 quotient; holds until the next done_out
overflow_out  output  1  quotient lies outside the signed 32-bit (Q24.8) range
div_by_zero_out  output  1  divisor was zero

Behaviour:
- Reset: while rst is high at a clock edge, state becomes IDLE and all outputs are driven to 0. Reset mid-operation aborts the division with no done_out.
- States:
  - IDLE: busy_out=0. If start_in is high, latch |a| into a 40-bit magnitude (|a| << 8, 33-bit abs so that -2^31 is handled), latch |b| (33-bit), record sign = a[31]^b[31], clear the partial remainder, set count=39, then go to DIV. If b_in==0, instead set the dbz flag and go to FIX.
  - DIV: busy_out=1. Each cycle: shift {rem, dividend} left by 1; if rem >= |b|, subtract |b| and set the quotient bit to 1, else set it to 0; decrement count. When count==0 and that bit is done, go to FIX. DIV lasts exactly 40 cycles.
  - FIX: busy_out=1. Register the outputs:
    - q_out = sign ? -mag : mag, zero-extended to 64 bits before negating.
    - overflow_out = (q_out < -2^31) || (q_out > 2^31-1).
    - On dbz: q_out=0, overflow_out=0, div_by_zero_out=1.
    - Pulse done_out=1 for the following cycle and go to IDLE.
- Latency:
  - Normal: done_out is high in the cycle after the 41st edge following the start-sampling edge.
  - Divide by zero: done_out is high after the 1st edge following the start-sampling edge.
- busy_out rises on the edge that accepts start and falls on the edge that raises done_out.
- start_in is ignored while busy_out=1. A start_in asserted in the same cycle as done_out is accepted, because the state is already IDLE.
- q_out, overflow_out and div_by_zero_out hold their values from one done_out until the next done_out or reset.
- Rounding is truncation toward zero. The remainder is discarded.
- The magnitude is at most 2^39, so q_out never wraps.

Decomposition:
- Package fixed_pkg holds:
  - FRACT_BITS, IN_W, OUT_W;
  - DIV_ITERS = IN_W + FRACT_BITS (40);
  - the state enum {IDLE, DIV, FIX}.
- The multiplier shares this package.
- No sub-module is required. The step logic (shift, compare, subtract) may be a function in fixed_pkg.

Test Plan:
- Basic division: a=0x00000180, b=0x00000080 (1.5/0.5) -> q_out=0x0000000000000300, overflow=0, dbz=0, done_out exactly 41 edges after start.
- Sign and truncation:
  - a=0xFFFFF900, b=0x00000200 (-7/2) -> q_out=0xFFFFFFFFFFFFFC80.
  - a=0x100, b=0x300 -> q_out=0x55.
  - a=0xFFFFFF00, b=0x300 -> q_out=0xFFFFFFFFFFFFFFAB.
- Overflow and extreme operands:
  - a=0x7FFFFFFF, b=0x00000001 -> q_out=0x0000007FFFFFFF00, overflow_out=1.
  - a=0x80000000, b=0xFFFFFF00 -> q_out=0x0000000080000000, overflow_out=1.
- Divide by zero: a=0x100, b=0 -> div_by_zero_out=1, q_out=0, done_out 1 edge after start.
- Handshake:
  - A start_in pulse at cycle 10 of a busy division is ignored; the original result is unchanged.
  - A back-to-back start in the done_out cycle is accepted, and the second result follows 41 edges later.
- Reset mid-operation: assert rst at cycle 20 of a division -> all outputs 0, no done_out; a fresh start afterwards completes correctly.
